mac_load_ctrl: RTL

MAC_LOAD_CTRL -- requirements
Module: mac_load_ctrl

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_bit_counter.sv | 32 +++
 rtl/mac_load_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC operand-load controller.
// The PAR_A/PAR_B states exist only when MAC_LOAD_PARITY_EN is defined.
package mac_pkg;

    localparam int WORD_LENGTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
`ifdef MAC_LOAD_PARITY_EN
        ,
        PAR_A  = 3'd6,
        PAR_B  = 3'd7
`endif
    } mac_state_e;

endpackage

// File: rtl/mac_bit_counter.sv
// Serial bit counter: counts accepted bits and flags the last bit of a word.
// Wraps to zero on the bit accepted at terminal count.
module mac_bit_counter #(
    parameter int WORD_LENGTH = mac_pkg::WORD_LENGTH_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic terminal_count
);

    localparam int CW = $clog2(WORD_LENGTH);
    localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);

    logic [CW-1:0] count;

    assign terminal_count = (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= terminal_count ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/mac_load_ctrl.sv
// Loads two MSB-first serial operands into external shift registers, launches the
// MAC and waits for it. Optional even-parity checking via MAC_LOAD_PARITY_EN.
module mac_load_ctrl
    import mac_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic serial_valid,
    input  logic serial_bit,
    input  logic mac_done,
    output logic shift_en_a,
    output logic shift_en_b,
    output logic shift_bit,
    output logic mac_start,
    output logic busy,
    output logic done,
    output logic error
);

`ifdef MAC_LOAD_PARITY_EN
    localparam mac_state_e AFTER_A = PAR_A;
    localparam mac_state_e AFTER_B = PAR_B;
`else
    localparam mac_state_e AFTER_A = LOAD_B;
    localparam mac_state_e AFTER_B = START;
`endif

    mac_state_e state;
    logic       cnt_clear;
    logic       cnt_inc;
    logic       cnt_tc;

    assign cnt_clear = (state == IDLE) && start;
    assign cnt_inc   = serial_valid && ((state == LOAD_A) || (state == LOAD_B));

    mac_bit_counter #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_bit_counter (
        .clk           (clk),
        .reset         (reset),
        .clear         (cnt_clear),
        .inc           (cnt_inc),
        .terminal_count(cnt_tc)
    );

    // Shift enables follow serial_valid in the same cycle; the rest decode state flops.
    assign shift_en_a = (state == LOAD_A) && serial_valid;
    assign shift_en_b = (state == LOAD_B) && serial_valid;
    assign shift_bit  = serial_bit;
    assign mac_start  = (state == START);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

`ifdef MAC_LOAD_PARITY_EN
    logic par_acc;
    logic error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
`ifdef MAC_LOAD_PARITY_EN
            par_acc <= 1'b0;
            error_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD_A;
`ifdef MAC_LOAD_PARITY_EN
                        par_acc <= 1'b0;
                        error_q <= 1'b0;
`endif
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (serial_valid) begin
`ifdef MAC_LOAD_PARITY_EN
                        par_acc <= par_acc ^ serial_bit;
`endif
                        if (cnt_tc) begin
                            state <= (state == LOAD_A) ? AFTER_A : AFTER_B;
                        end
                    end
                end
`ifdef MAC_LOAD_PARITY_EN
                // Even parity: the check bit must equal the XOR of the operand bits.
                PAR_A, PAR_B: begin
                    if (serial_valid) begin
                        par_acc <= 1'b0;
                        if (serial_bit == par_acc) begin
                            state <= (state == PAR_A) ? LOAD_B : START;
                        end else begin
                            error_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
`endif
                START:   state <= WAIT;
                WAIT:    if (mac_done) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
